// File: rtl/e_mdu.sv
// e_mdu: multiply/divide unit for the E stage of a MIPS-style pipeline.
//
// The result of mult/multu/div/divu is computed in the cycle the op starts
// and held internally. It is written to HI/LO only when a fixed busy period
// has run out, so software sees the latency of an iterative unit.
//
// Ports:
//   clk       in   1  clock, rising edge
//   reset     in   1  synchronous reset, active low (0 = reset)
//   cancel    in   1  flush of the in-flight op (only with E_MDU_CANCEL_EN)
//   MDUOp     in   4  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   Src_A     in  32  rs operand (forwarded)
//   Src_B     in  32  rt operand (forwarded)
//   HI        out 32  architectural HI
//   LO        out 32  architectural LO
//   MDU_busy  out  1  multiply/divide in flight
//
// Build option: define E_MDU_CANCEL_EN to add the cancel port.
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef E_MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic [3:0]  MDUOp,
    input  logic [31:0] Src_A,
    input  logic [31:0] Src_B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        MDU_busy
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] res_hi_q, res_hi_d;
    logic [31:0] res_lo_q, res_lo_d;
    // Cleared for divide by zero so the busy period runs without a commit.
    logic        res_ok_q, res_ok_d;

    logic        busy;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        sdiv;
    logic [31:0] dvd_mag;
    logic [31:0] dvs_mag;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    assign busy     = (cnt_q != 4'd0);
    assign MDU_busy = busy;
    assign HI       = hi_q;
    assign LO       = lo_q;

    // Sign-extending to 64 bits and keeping the low 64 bits of the product
    // gives the exact two's-complement signed product.
    assign prod_s = {{32{Src_A[31]}}, Src_A} * {{32{Src_B[31]}}, Src_B};
    assign prod_u = {32'd0, Src_A} * {32'd0, Src_B};

    // Signed divide goes through magnitudes; 0x80000000 / -1 then yields
    // quotient 0x80000000, remainder 0 without special casing.
    always_comb begin
        sdiv    = (MDUOp == OP_DIV);
        dvd_mag = (sdiv && Src_A[31]) ? (32'd0 - Src_A) : Src_A;
        dvs_mag = (sdiv && Src_B[31]) ? (32'd0 - Src_B) : Src_B;
        q_mag   = 32'd0;
        r_mag   = 32'd0;
        if (dvs_mag != 32'd0) begin
            q_mag = dvd_mag / dvs_mag;
            r_mag = dvd_mag % dvs_mag;
        end
        quot = (sdiv && (Src_A[31] ^ Src_B[31])) ? (32'd0 - q_mag) : q_mag;
        rem  = (sdiv && Src_A[31]) ? (32'd0 - r_mag) : r_mag;
    end

    always_comb begin
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        res_hi_d = res_hi_q;
        res_lo_d = res_lo_q;
        res_ok_d = res_ok_q;

        if (busy) begin
            // Every op is ignored while busy; the last busy cycle commits.
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1 && res_ok_q) begin
                hi_d = res_hi_q;
                lo_d = res_lo_q;
            end
        end else begin
            case (MDUOp)
                OP_MULT: begin
                    cnt_d    = 4'(MULT_CYCLES);
                    res_hi_d = prod_s[63:32];
                    res_lo_d = prod_s[31:0];
                    res_ok_d = 1'b1;
                end
                OP_MULTU: begin
                    cnt_d    = 4'(MULT_CYCLES);
                    res_hi_d = prod_u[63:32];
                    res_lo_d = prod_u[31:0];
                    res_ok_d = 1'b1;
                end
                OP_DIV, OP_DIVU: begin
                    cnt_d    = 4'(DIV_CYCLES);
                    res_hi_d = rem;
                    res_lo_d = quot;
                    res_ok_d = (Src_B != 32'd0);
                end
                OP_MTHI: hi_d = Src_A;
                OP_MTLO: lo_d = Src_A;
                default: ;
            endcase
        end

`ifdef E_MDU_CANCEL_EN
        // Flush wins over everything: no commit, no start, no move.
        if (cancel) begin
            cnt_d    = 4'd0;
            res_ok_d = 1'b0;
            hi_d     = hi_q;
            lo_d     = lo_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt_q    <= 4'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            res_hi_q <= 32'd0;
            res_lo_q <= 32'd0;
            res_ok_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            res_hi_q <= res_hi_d;
            res_lo_q <= res_lo_d;
            res_ok_q <= res_ok_d;
        end
    end

endmodule

// File: tb/tb_e_mdu.sv
// Testbench for e_mdu: table of ops chained back to back, a scoreboard queue
// of expected HI/LO/busy-length, and hand-written reset/ignore/cancel cases.
module tb_e_mdu;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic [3:0]  MDUOp;
    logic [31:0] Src_A;
    logic [31:0] Src_B;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        MDU_busy;

    e_mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef E_MDU_CANCEL_EN
        .cancel   (cancel),
`endif
        .MDUOp    (MDUOp),
        .Src_A    (Src_A),
        .Src_B    (Src_B),
        .HI       (HI),
        .LO       (LO),
        .MDU_busy (MDU_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          busy;
    } vec_t;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [7:0]  busy;
    } exp_t;

    exp_t        sb[$];
    vec_t        tbl[16];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] cur_hi;
    logic [31:0] cur_lo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Called at a negedge just after the start edge has passed (n0 busy
    // cycles already seen). Counts busy cycles, checks HI/LO hold, then
    // pops the scoreboard and compares the committed result.
    task automatic wait_done(input int id, input int n0);
        exp_t e;
        int   n;
        logic done;
        n    = n0;
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (MDU_busy) begin
                n++;
                chk($sformatf("hold_hi[%0d]", id), HI, cur_hi);
                chk($sformatf("hold_lo[%0d]", id), LO, cur_lo);
            end else begin
                done = 1'b1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL timeout[%0d]: busy still high after 40 cycles", id);
        end
        e = sb.pop_front();
        chk($sformatf("busy_len[%0d]", id), 32'(n), 32'(e.busy));
        chk($sformatf("hi[%0d]", id), HI, e.hi);
        chk($sformatf("lo[%0d]", id), LO, e.lo);
        $display("op %0d: busy=%0d HI=%h LO=%h", id, n, HI, LO);
        cur_hi = e.hi;
        cur_lo = e.lo;
    endtask

    // Must be called at a negedge with the unit idle.
    task automatic run_op(input int id, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi,
                          input logic [31:0] elo, input int ebusy);
        sb.push_back('{ehi, elo, 8'(ebusy)});
        MDUOp = op;
        Src_A = a;
        Src_B = b;
        @(posedge clk);
        #1;
        // Scrambled operands after the start edge must not affect the result.
        MDUOp = 4'd0;
        Src_A = $urandom;
        Src_B = $urandom;
        wait_done(id, 0);
    endtask

    initial begin
        tbl[0]  = '{4'd1, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 5};
        tbl[1]  = '{4'd2, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 5};
        tbl[2]  = '{4'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[3]  = '{4'd4, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        tbl[4]  = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        tbl[5]  = '{4'd5, 32'h12345678, 32'h00000000, 32'h12345678, 32'h80000000, 0};
        tbl[6]  = '{4'd6, 32'h9ABCDEF0, 32'h00000000, 32'h12345678, 32'h9ABCDEF0, 0};
        tbl[7]  = '{4'd4, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 10};
        tbl[8]  = '{4'd3, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        tbl[9]  = '{4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
        tbl[10] = '{4'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 5};
        tbl[11] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
        tbl[12] = '{4'd7, 32'h55555555, 32'h00000003, 32'hFFFFFFFE, 32'h00000001, 0};
        tbl[13] = '{4'd1, 32'h00000003, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'hFFFFFFF4, 5};
        tbl[14] = '{4'd3, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFF4, 10};
        tbl[15] = '{4'd4, 32'h00000000, 32'h00000005, 32'h00000000, 32'h00000000, 10};

        reset  = 1'b0;
        cancel = 1'b0;
        MDUOp  = 4'd1;
        Src_A  = 32'd3;
        Src_B  = 32'd3;
        repeat (2) @(posedge clk);
        #1;
        MDUOp = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        chk("reset_busy", 32'(MDU_busy), 32'd0);
        chk("reset_hi", HI, 32'd0);
        chk("reset_lo", LO, 32'd0);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

        // mult 3 x 4 with mthi presented on its 2nd busy cycle.
        sb.push_back('{32'd0, 32'h0000000C, 8'd5});
        MDUOp = 4'd1;
        Src_A = 32'd3;
        Src_B = 32'd4;
        @(posedge clk);
        #1;
        MDUOp = 4'd0;
        @(negedge clk);
        chk("ign_busy1", 32'(MDU_busy), 32'd1);
        @(negedge clk);
        chk("ign_busy2", 32'(MDU_busy), 32'd1);
        MDUOp = 4'd5;
        Src_A = 32'h0000DEAD;
        @(posedge clk);
        #1;
        MDUOp = 4'd0;
        wait_done(100, 2);
        run_op(101, 4'd5, 32'h0000DEAD, 32'd0, 32'h0000DEAD, 32'h0000000C, 0);

        // Table ops are chained so each start lands in the first idle cycle.
        for (int i = 0; i < 16; i++)
            run_op(i, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hi, tbl[i].lo, tbl[i].busy);

        // Reset on the 4th busy cycle of a divide.
        run_op(102, 4'd5, 32'hCAFEF00D, 32'd0, 32'hCAFEF00D, 32'd0, 0);
        MDUOp = 4'd3;
        Src_A = 32'd100;
        Src_B = 32'd7;
        @(posedge clk);
        #1;
        MDUOp = 4'd0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_busy", 32'(MDU_busy), 32'd0);
        chk("rst_mid_hi", HI, 32'd0);
        chk("rst_mid_lo", LO, 32'd0);
        repeat (12) @(negedge clk);
        chk("rst_late_hi", HI, 32'd0);
        chk("rst_late_lo", LO, 32'd0);
        $display("op 103: reset mid-divide HI=%h LO=%h", HI, LO);

        // Start presented together with reset is dropped.
        reset = 1'b0;
        MDUOp = 4'd2;
        Src_A = 32'd9;
        Src_B = 32'd9;
        @(posedge clk);
        #1;
        reset = 1'b1;
        MDUOp = 4'd0;
        @(negedge clk);
        chk("rst_start_busy", 32'(MDU_busy), 32'd0);
        repeat (7) @(negedge clk);
        chk("rst_start_lo", LO, 32'd0);
        $display("op 104: start with reset busy=%0d LO=%h", MDU_busy, LO);
        cur_hi = 32'd0;
        cur_lo = 32'd0;

`ifdef E_MDU_CANCEL_EN
        run_op(105, 4'd6, 32'h11112222, 32'd0, 32'd0, 32'h11112222, 0);
        MDUOp = 4'd2;
        Src_A = 32'hFFFFFFFF;
        Src_B = 32'h00000002;
        @(posedge clk);
        #1;
        MDUOp = 4'd0;
        repeat (2) @(negedge clk);
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        chk("cancel_busy", 32'(MDU_busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("cancel_hi", HI, 32'd0);
        chk("cancel_lo", LO, 32'h11112222);
        $display("op 106: cancel busy=%0d HI=%h LO=%h", MDU_busy, HI, LO);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/e_mdu.md
E_MDU -- requirements
Module: e_mdu

Interface
REQ-001 Parameter MULT_CYCLES, default 5, is the busy duration of mult/multu in cycles (legal range 1..15).
REQ-002 Parameter DIV_CYCLES, default 10, is the busy duration of div/divu in cycles (legal range 1..15).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-low reset; sampled on clk rising edge, 0 = reset.
REQ-005 MDUOp  input  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7-15 none.
REQ-006 Src_A  input  32  forwarded rs value (MF_Rs_E).
REQ-007 Src_B  input  32  forwarded rt value (MF_Rt_E).
REQ-008 HI  output  32  architectural HI register.
REQ-009 LO  output  32  architectural LO register.
REQ-010 MDU_busy  output  1  high while a multiply/divide is in flight; consumed by the stall unit.

Function
REQ-011 "Start" is defined as MDUOp in 1..4 in a cycle where MDU_busy is 0 and reset is 1.
REQ-012 On start, the block latches the full result (64-bit product, or quotient/remainder) computed from the Src_A/Src_B values of that cycle, and loads an internal 4-bit counter with MULT_CYCLES or DIV_CYCLES.
REQ-013 MDU_busy is registered: start in cycle T gives MDU_busy = 1 in cycles T+1 through T+N, where N is the loaded count. MDU_busy = 0 in cycle T+N+1.
REQ-014 HI/LO are committed at the rising edge that ends cycle T+N. New values are visible from cycle T+N+1. HI/LO hold their old values throughout T..T+N.
REQ-015 mult: {HI,LO} = signed(Src_A) x signed(Src_B). multu: the same operation, unsigned.
REQ-016 div: LO = quotient truncated toward zero, HI = remainder carrying the sign of the dividend. divu: the same operation, unsigned.
REQ-017 Signed overflow (div 0x80000000 / 0xFFFFFFFF) gives LO = 0x80000000, HI = 0.
REQ-018 Divide by zero (div or divu): the op runs the full DIV_CYCLES busy period, then HI and LO are left unchanged.
REQ-019 mthi/mtlo with MDU_busy = 0 write Src_A into HI/LO at the end of that cycle, with no busy period.
REQ-020 While MDU_busy = 1, any MDUOp, including 1..6, is ignored. No restart occurs and HI/LO are untouched. The stall unit guarantees no such op is retired.
REQ-021 Back-to-back operation: a start is accepted in cycle T+N+1, the first cycle with MDU_busy = 0.
REQ-022 Counter wrap is impossible: the counter decrements only while non-zero, and MDU_busy = (counter != 0).

Reset
REQ-023 When reset = 0 at a clk rising edge: HI = 0, LO = 0, counter = 0, MDU_busy = 0, and the pending result is discarded. This also applies mid-operation; no commit ever follows.
REQ-024 A start presented in the same cycle as reset = 0 is discarded.
REQ-025 Outputs are defined from the first edge with reset = 0; no asynchronous behaviour exists.

Configuration
REQ-026 With macro E_MDU_CANCEL_EN defined, the block adds port "cancel  input  1  flush of in-flight MDU op (exception/eret)".
REQ-027 With E_MDU_CANCEL_EN defined, cancel = 1 at an edge clears the counter and discards the pending result. MDU_busy is 0 in the next cycle, HI/LO are unchanged, and a start in the same cycle is also discarded.
REQ-028 Without E_MDU_CANCEL_EN, the cancel port does not exist and behaviour is exactly REQ-011..REQ-025.

Verification
REQ-029 Signed mult: mult with Src_A = 0xFFFFFFFF, Src_B = 0x00000002 -> MDU_busy high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
REQ-030 Unsigned mult: multu with the same operands -> HI = 0x00000001, LO = 0xFFFFFFFE after 5 busy cycles.
REQ-031 Signed div and divide by zero: div with Src_A = 0xFFFFFFF9 (-7), Src_B = 2 -> 10 busy cycles, then LO = 0xFFFFFFFD, HI = 0xFFFFFFFF. A following divu with Src_B = 0 -> 10 busy cycles, HI/LO unchanged.
REQ-032 Ignore while busy: mult 3 x 4 started, mthi 0xDEAD presented on its 2nd busy cycle -> mthi ignored, final HI = 0, LO = 0x0000000C. mthi 0xDEAD presented afterward while idle -> HI = 0x0000DEAD next cycle, no busy.
REQ-033 Reset mid-operation: div started, reset = 0 on its 4th busy cycle -> next cycle MDU_busy = 0, HI = LO = 0, and no later commit.
REQ-034 Cancel (macro defined): multu started, cancel = 1 on its 2nd busy cycle -> MDU_busy = 0 next cycle, HI/LO keep their prior values.
